// File: rtl/tail_light_pkg.sv
// Shared types and lamp constants for the tail-light sequencer.
// The HZ encoding is always defined; it is only reachable with TAIL_LIGHT_HAZARD_EN.
package tail_light_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_HZ   = 3'd7
  } state_t;

  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_1   = 3'b001;
  localparam logic [2:0] LAMPS_2   = 3'b011;
  localparam logic [2:0] LAMPS_3   = 3'b111;

  // Right-side lamps are ordered {RA,RB,RC}, so their pattern is the mirror of the left one.
  function automatic logic [2:0] mirror3(input logic [2:0] p);
    return {p[0], p[1], p[2]};
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Moore decode of the sequencer state into the two three-lamp clusters.
// The HZ pattern is decoded only when TAIL_LIGHT_HAZARD_EN is defined.
module lamp_decode
  import tail_light_pkg::*;
(
  input  logic [2:0] state,
  output logic [2:0] left_lamps,
  output logic [2:0] right_lamps
);

  logic [2:0] left_pat;
  logic [2:0] right_pat;

  always_comb begin
    left_pat  = LAMPS_OFF;
    right_pat = LAMPS_OFF;
    case (state_t'(state))
      ST_L1: left_pat  = LAMPS_1;
      ST_L2: left_pat  = LAMPS_2;
      ST_L3: left_pat  = LAMPS_3;
      ST_R1: right_pat = LAMPS_1;
      ST_R2: right_pat = LAMPS_2;
      ST_R3: right_pat = LAMPS_3;
`ifdef TAIL_LIGHT_HAZARD_EN
      ST_HZ: begin
        left_pat  = LAMPS_3;
        right_pat = LAMPS_3;
      end
`endif
      default: ;
    endcase
  end

  assign left_lamps  = left_pat;
  assign right_lamps = mirror3(right_pat);

endmodule

// File: rtl/tail_light_seq.sv
// Tick-driven left/right turn sweep sequencer with completed-sequence counter.
// Optional hazard flash is built in when TAIL_LIGHT_HAZARD_EN is defined.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int SEQ_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 left,
  input  logic                 right,
  input  logic                 hazard,
  output logic [2:0]           left_lamps,
  output logic [2:0]           right_lamps,
  output logic                 busy,
  output logic                 seq_done,
  output logic [SEQ_CNT_W-1:0] seq_count,
  output logic [2:0]           state_dbg
);

  // clk_en is a one-cycle advance qualifier with no back-pressure: the machine
  // consumes every tick it sees, and the requests are sampled only on ticks taken in IDLE.
  state_t state;
  state_t state_nxt;
  logic   haz_req;
  logic   seq_end;

`ifdef TAIL_LIGHT_HAZARD_EN
  assign haz_req = hazard | (left & right);
`else
  logic unused_hazard;
  assign unused_hazard = hazard;
  assign haz_req       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (haz_req)    state_nxt = ST_HZ;
        else if (left)  state_nxt = ST_L1;
        else if (right) state_nxt = ST_R1;
      end
      ST_L1:   state_nxt = ST_L2;
      ST_L2:   state_nxt = ST_L3;
      ST_R1:   state_nxt = ST_R2;
      ST_R2:   state_nxt = ST_R3;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign seq_end = (state == ST_L3) || (state == ST_R3) || (state == ST_HZ);

  // seq_done clears on any edge; everything else advances only on a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      seq_done  <= 1'b0;
      seq_count <= '0;
    end else begin
      seq_done <= 1'b0;
      if (clk_en) begin
        state <= state_nxt;
        if (seq_end) begin
          seq_done  <= 1'b1;
          seq_count <= seq_count + SEQ_CNT_W'(1);
        end
      end
    end
  end

  lamp_decode u_lamp_decode (
    .state       (state),
    .left_lamps  (left_lamps),
    .right_lamps (right_lamps)
  );

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/tail_light_seq.md
# tail_light_seq

Tick-driven tail-light sequencer: the consumer end of the clock-divider enable. It advances a Moore state machine only on cycles where the divider's one-cycle `clk_en` pulse is high, producing the classic three-lamp left/right turn sweep and an optional hazard flash. It sits between the divider and the board LEDs, on the same fast system clock as the divider. Nothing in it is clocked by a derived clock.

## Interface
- SEQ_CNT_W, 8: width of the completed-sequence counter.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- clk_en  input  1  one-cycle advance tick from the clock divider; may be held high (advance every cycle).
- left  input  1  left-turn request, level, synchronous to clk.
- right  input  1  right-turn request, level.
- hazard  input  1  hazard request, level; used only when the hazard feature is compiled in.
- left_lamps  output  3  {LC,LB,LA}; LA is innermost.
- right_lamps  output  3  {RA,RB,RC}; RA is innermost.
- busy  output  1  high whenever state != IDLE.
- seq_done  output  1  one-cycle pulse on the clk edge where state returns to IDLE.
- seq_count  output  SEQ_CNT_W  number of completed sequences, modulo 2^SEQ_CNT_W.

## Operation
- States: IDLE, L1, L2, L3, R1, R2, R3, HZ.
- State, seq_done and seq_count update only on clk edges where clk_en=1. Exception: seq_done clears on the first edge after it is set, whatever clk_en is.
- IDLE on tick, priority order:
  - hazard request -> HZ.
  - left -> L1.
  - right -> R1.
  - none -> stay in IDLE.
- Hazard request is `hazard | (left & right)` with the feature built in.
- Sequences: L1->L2->L3->IDLE, R1->R2->R3->IDLE, HZ->IDLE, one transition per tick.
- Once a sequence has started it always completes. Input changes mid-sequence are ignored.
- Lamps are a Moore decode of the state register:
  - IDLE: 000/000.
  - L1: left_lamps=001. L2: 011. L3: 111. right_lamps=000 throughout.
  - R1: right_lamps=100. R2: 110. R3: 111. left_lamps=000 throughout.
  - HZ: both 111.
- On every tick-qualified transition into IDLE from L3, R3 or HZ:
  - seq_done=1 for exactly one cycle.
  - seq_count increments. It wraps from 2^SEQ_CNT_W-1 to 0.
- A sustained request restarts the sequence. After IDLE is reached, the next tick samples the inputs again. This gives the repeating pattern L1,L2,L3,IDLE,L1…

## Timing
- Reset (rst=0), asynchronous:
  - State goes to IDLE immediately, without waiting for a clock edge.
  - All lamps=0, busy=0, seq_done=0, seq_count=0.
  - This holds regardless of clk_en and applies even mid-sequence.
- Reset release: the first tick after rst rises is evaluated normally.
- Latency:
  - Inputs are sampled on the clk edge with clk_en=1.
  - New lamp pattern, busy and seq_done are visible right after that edge.
  - Request to first lamp is one tick.
- clk_en high every cycle: the machine steps every clk. A full left sequence is 3 cycles plus 1 IDLE cycle.
- clk_en=0: state, lamps, busy and seq_count hold.

## Configuration
- TAIL_LIGHT_HAZARD_EN defined:
  - HZ state is reachable.
  - `hazard=1` or `left&right=1` in IDLE -> HZ. Hazard has priority over left and right.
- Not defined:
  - HZ state and hazard logic are absent. The `hazard` port remains and is ignored.
  - `left&right=1` in IDLE -> L1 (left priority).

## Structure
- Package tail_light_pkg holds:
  - the state enum (typedef, 3 bits);
  - the lamp constants LAMPS_OFF=3'b000, LAMPS_1=3'b001, LAMPS_2=3'b011, LAMPS_3=3'b111.
- Right-side patterns are the bit-reversal of the left-side patterns.
- One sub-module, lamp_decode: purely combinational decode from state to {left_lamps,right_lamps}.
- The state register, counter and done logic live in the top module.

## Test plan
- Reset and hold:
  - rst=0 for 3 cycles -> lamps 000/000, busy=0, seq_count=0.
  - Then pulse clk_en every 4 clk with no requests -> outputs unchanged.
- Left sweep:
  - left=1 held, clk_en every 4 clk.
  - After ticks 1/2/3 -> left_lamps 001/011/111.
  - After tick 4 -> 000, seq_done pulses for exactly 1 clk, seq_count=1.
- Mid-sequence input change and reset:
  - Start right. Drop right and raise left at R1 -> R2, R3 still complete.
  - Repeat, and assert rst=0 mid-R2 between edges -> lamps 000 immediately.
- Hazard:
  - With TAIL_LIGHT_HAZARD_EN, left=right=1 -> HZ (111/111) for one tick, then IDLE.
  - Without the macro, left=right=1 -> L1 (001/000).
  - Without the macro, hazard=1 alone -> stays IDLE.
- Continuous tick and wrap:
  - clk_en=1 permanently, right=1, SEQ_CNT_W=2.
  - Pattern advances every clk.
  - After 4 completed sequences seq_count wraps 3->0 and seq_done pulses each time.
